// File: rtl/fifo_pkg.sv
// Shared constants and parameter helpers for the single-clock parametrised FIFO.
// The legality helpers are evaluated at elaboration time by the FIFO top.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_legal(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, registered read with enable.
// The storage array is intentionally not reset; only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register; a same-address write in this cycle is not bypassed, the old word is returned.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO: pointers, occupancy, threshold flags and sticky errors.
// All status outputs are registered from the next-state occupancy so they track the causing edge.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_enable_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_enable_i,
  input  logic                   err_clr_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic                   error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
  end
  if (!thresh_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("fifo_sync_param: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          full_r, empty_r, afull_r, aempty_r;
  logic          ovf_r, unf_r, err_r;
  logic          rd_acc_s, wr_acc_s, ovf_nxt_s, unf_nxt_s;

  // Accept decisions and next-state occupancy / sticky flags.
  always_comb begin
    rd_acc_s    = rd_enable_i & ~empty_r;
    wr_acc_s    = wr_enable_i & (~full_r | rd_acc_s);
    count_nxt_s = count_r + CW'(wr_acc_s) - CW'(rd_acc_s);
    if (wr_enable_i & ~wr_acc_s) begin
      ovf_nxt_s = 1'b1;
    end else if (err_clr_i) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
    if (rd_enable_i & ~rd_acc_s) begin
      unf_nxt_s = 1'b1;
    end else if (err_clr_i) begin
      unf_nxt_s = 1'b0;
    end else begin
      unf_nxt_s = unf_r;
    end
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      empty_r  <= (count_nxt_s == {CW{1'b0}});
      afull_r  <= (count_nxt_s >= CW'(AF_THRESH));
      aempty_r <= (count_nxt_s <= CW'(AE_THRESH));
      ovf_r    <= ovf_nxt_s;
      unf_r    <= unf_nxt_s;
      err_r    <= ovf_nxt_s | unf_nxt_s;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data_i),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_o)
  );

  assign full_o         = full_r;
  assign empty_o        = empty_r;
  assign almost_full_o  = afull_r;
  assign almost_empty_o = aempty_r;
  assign count_o        = count_r;
  assign overflow_o     = ovf_r;
  assign underflow_o    = unf_r;
  assign error_o        = err_r;

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised synchronous FIFO; next-generation replacement for the fixed-width dual-clock FIFO used in the verification projects. Adds a compile-time depth, programmable almost-full/almost-empty thresholds, an occupancy count, and separate sticky overflow/underflow flags with software clear. Sits between a producer and consumer in the same clock domain; the FIFO UVM agent drives and monitors it directly.

## Interface
- WIDTH, 8: data word width in bits (≥1)
- DEPTH, 16: number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2: almost_full_o asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2: almost_empty_o asserts when count ≤ AE_THRESH (0..DEPTH-1)

- clk_i  input  1  single clock, rising edge
- rst_i  input  1  asynchronous active-low reset
- wr_enable_i  input  1  write request
- wr_data_i  input  WIDTH  write data
- rd_enable_i  input  1  read request
- err_clr_i  input  1  clears sticky error flags
- rd_data_o  output  WIDTH  read data, registered
- full_o  output  1  count == DEPTH
- empty_o  output  1  count == 0
- almost_full_o  output  1  count ≥ AF_THRESH
- almost_empty_o  output  1  count ≤ AE_THRESH
- count_o  output  $clog2(DEPTH)+1  current occupancy
- overflow_o  output  1  sticky: write rejected
- underflow_o  output  1  sticky: read rejected
- error_o  output  1  overflow_o | underflow_o

## Operation
- Read accept: rd_acc = rd_enable_i & ~empty_o.
- Write accept: wr_acc = wr_enable_i & (~full_o | rd_acc); a write at full succeeds only alongside an accepted read.
- At empty, simultaneous read+write: write accepted, read rejected (no bypass), underflow set.
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally DEPTH-1 → 0.
- count next = count + wr_acc − rd_acc; never exceeds DEPTH, never below 0.
- rd_data_o loads mem[rd_ptr] on rd_acc; otherwise holds its value.
- overflow_o sets on wr_enable_i & ~wr_acc; underflow_o sets on rd_enable_i & ~rd_acc.
- err_clr_i clears both flags; a set event in the same cycle wins over clear.
- Memory contents are not reset; reads after reset return only written data.

## Timing
- Reset (rst_i low, asynchronous): pointers 0, count_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, rd_data_o 0, overflow_o/underflow_o/error_o 0. Release is synchronised by the integrator; the block samples normally from the first edge after rst_i rises.
- Write latency: data written at edge N is readable (empty_o low) after edge N; an rd_acc at edge N+1 presents it on rd_data_o after edge N+1.
- Read latency: 1 cycle from rd_acc edge to valid rd_data_o.
- All flags and count_o are registered/derived from registered count and update at the same edge as the operation causing them; no combinational path from enables to outputs.
- Reset asserted mid-burst: all state returns to reset values immediately; in-flight data is discarded.

## Structure
- fifo_pkg: default WIDTH/DEPTH constants, function computing count width, parameter-legality checks (DEPTH power of two, threshold ranges) as elaboration-time assertions.
- Sub-module fifo_mem: DEPTH×WIDTH simple dual-port array, synchronous write, registered read with read-enable; top holds pointers, count, flags, and error logic.
- WIDTH macro usage is replaced by parameters throughout.

## Test plan
(WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
- Reset then idle → empty_o=1, almost_empty_o=1, count_o=0, rd_data_o=0x00, error_o=0.
- Write 0x11,0x22,0x33,0x44 then read 4 → count 1,2,3,4; almost_full_o at count 3; full_o at 4; reads return 0x11..0x44 in order, one cycle after each rd_acc; empty_o=1 at end.
- At full, write 0x55 alone → rejected, overflow_o=1, error_o=1, count stays 4; err_clr_i pulse → flags 0.
- At full, read+write 0x66 together → both accepted, count stays 4, full_o stays 1, no overflow; 0x66 read last after wrap-around.
- At empty, read+write 0x77 → write accepted, count 1, underflow_o=1; next read returns 0x77.
- Assert rst_i low mid-burst at count 2 → outputs immediately at reset values; subsequent write 0x88/read returns 0x88.
